// File: rtl/anim_pkg.sv
// Shared widths, FSM state type and limit decoding for the animation frame sequencer.
package anim_pkg;
   localparam int ANIM_W     = 5;
   localparam int FRAME_W    = 5;
   localparam int MAX_FRAMES = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   // A frame count of zero stands for the full 32-frame animation.
   function automatic logic [FRAME_W:0] eff_limit(input logic [FRAME_W-1:0] limit);
      logic [FRAME_W:0] l;
      if (limit == {FRAME_W{1'b0}}) begin
         l = 6'(MAX_FRAMES);
      end else begin
         l = {1'b0, limit};
      end
      return l;
   endfunction
endpackage

// File: rtl/anim_frame_ctr.sv
// Up/down modulo-L frame counter with registered frame index and one-cycle wrap pulse.
module anim_frame_ctr
   import anim_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               adv,
   input  logic               reverse,
   input  logic               clr,
   input  logic               zero_on_wrap,
   input  logic [FRAME_W:0]   lim,
   output logic [FRAME_W-1:0] frame,
   output logic               wrap,
   output logic               wrap_hit
);
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               wrap_q, wrap_d;
   logic [FRAME_W:0]   last_s;
   logic [FRAME_W:0]   frame_x_s;
   logic               hit_s;

   // Next frame: a frame already at or beyond L-1 (limit shrank) is treated as the wrap point.
   always_comb begin
      last_s    = lim - 6'd1;
      frame_x_s = {1'b0, frame_q};
      frame_d   = frame_q;
      wrap_d    = 1'b0;
      wrap_hit  = 1'b0;
      if (reverse) begin
         hit_s = (frame_q == 5'd0);
      end else begin
         hit_s = (frame_x_s >= last_s);
      end
      if (clr) begin
         frame_d = 5'd0;
      end else if (adv) begin
         wrap_hit = hit_s;
         wrap_d   = hit_s;
         if (hit_s) begin
            if (zero_on_wrap || !reverse) begin
               frame_d = 5'd0;
            end else begin
               frame_d = last_s[FRAME_W-1:0];
            end
         end else if (reverse) begin
            if (frame_x_s > last_s) begin
               frame_d = last_s[FRAME_W-1:0];
            end else begin
               frame_d = frame_q - 5'd1;
            end
         end else begin
            frame_d = frame_q + 5'd1;
         end
      end else begin
         frame_d = frame_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= 5'd0;
         wrap_q  <= 1'b0;
      end else begin
         frame_q <= frame_d;
         wrap_q  <= wrap_d;
      end
   end

   assign frame = frame_q;
   assign wrap  = wrap_q;
endmodule

// File: rtl/animation_sequencer.sv
// Frame sequencer: run/pause FSM, queued or immediate animation switching, frame stepping.
module animation_sequencer
   import anim_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               run,
   input  logic               step,
   input  logic               reverse,
   input  logic [ANIM_W-1:0]  anim_sel,
   input  logic               anim_load,
   input  logic               immediate,
   input  logic [FRAME_W-1:0] limit,
   output logic [ANIM_W-1:0]  anim_cur,
   output logic [FRAME_W-1:0] frame,
   output logic               wrap,
   output logic               pending
);
   state_e             state_q, state_d;
   logic [ANIM_W-1:0]  anim_cur_q, anim_cur_d;
   logic [ANIM_W-1:0]  pend_id_q, pend_id_d;
   logic               pending_q, pending_d;
   logic               load_imm_s, load_q_s, adv_s, wrap_hit_s, apply_s;

   // Advance qualification; an immediate load discards any advance in the same cycle.
   always_comb begin
      load_imm_s = anim_load && immediate;
      load_q_s   = anim_load && !immediate;
      if (load_imm_s) begin
         adv_s = 1'b0;
      end else begin
         adv_s = ((state_q == RUN) && tick) || ((state_q == PAUSE) && step);
      end
   end

   anim_frame_ctr u_ctr (
      .clk          (clk),
      .rst          (rst),
      .adv          (adv_s),
      .reverse      (reverse),
      .clr          (load_imm_s),
      .zero_on_wrap (pending_q || load_q_s),
      .lim          (eff_limit(limit)),
      .frame        (frame),
      .wrap         (wrap),
      .wrap_hit     (wrap_hit_s)
   );

   // FSM next state plus pending/animation bookkeeping; a load on the wrapping advance wins.
   always_comb begin
      state_d    = state_q;
      anim_cur_d = anim_cur_q;
      pend_id_d  = pend_id_q;
      pending_d  = pending_q;
      apply_s    = wrap_hit_s && (pending_q || load_q_s);
      case (state_q)
         IDLE:    state_d = run ? RUN : IDLE;
         RUN:     state_d = run ? RUN : PAUSE;
         PAUSE:   state_d = run ? RUN : PAUSE;
         default: state_d = IDLE;
      endcase
      if (load_q_s) begin
         pend_id_d = anim_sel;
      end else begin
         pend_id_d = pend_id_q;
      end
      if (load_imm_s) begin
         anim_cur_d = anim_sel;
         pending_d  = 1'b0;
      end else if (apply_s) begin
         anim_cur_d = load_q_s ? anim_sel : pend_id_q;
         pending_d  = 1'b0;
      end else if (load_q_s) begin
         pending_d  = 1'b1;
      end else begin
         pending_d  = pending_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         anim_cur_q <= 5'd0;
         pend_id_q  <= 5'd0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         anim_cur_q <= anim_cur_d;
         pend_id_q  <= pend_id_d;
         pending_q  <= pending_d;
      end
   end

   assign anim_cur = anim_cur_q;
   assign pending  = pending_q;
endmodule

// File: tb/tb_animation_sequencer.sv
// Scoreboard bench: directed stimulus queues expected outputs, a monitor compares each cycle.
module tb_animation_sequencer;
   logic       clk = 1'b0;
   logic       rst, tick, run, step, reverse, anim_load, immediate;
   logic [4:0] anim_sel, limit;
   logic [4:0] anim_cur, frame;
   logic       wrap, pending;

   typedef struct {
      int         id;
      logic [4:0] anim;
      logic [4:0] frm;
      logic       wr;
      logic       pend;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;

   animation_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .run       (run),
      .step      (step),
      .reverse   (reverse),
      .anim_sel  (anim_sel),
      .anim_load (anim_load),
      .immediate (immediate),
      .limit     (limit),
      .anim_cur  (anim_cur),
      .frame     (frame),
      .wrap      (wrap),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // Push the outputs expected after the coming edge, then release one-cycle strobes.
   task automatic expect_next(input logic [4:0] a, input logic [4:0] f,
                              input logic w, input logic p);
      exp_t e;
      e.id = vec_id; e.anim = a; e.frm = f; e.wr = w; e.pend = p;
      vec_id++;
      exp_q.push_back(e);
      @(negedge clk);
      tick = 1'b0; step = 1'b0; anim_load = 1'b0; immediate = 1'b0; rst = 1'b0;
   endtask

   // Monitor: outputs are presented every cycle, sampled 1ns after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (anim_cur !== e.anim || frame !== e.frm || wrap !== e.wr || pending !== e.pend) begin
               errors++;
               $display("FAIL vec%0d: got anim=%0d frame=%0d wrap=%0b pend=%0b, want anim=%0d frame=%0d wrap=%0b pend=%0b",
                        e.id, anim_cur, frame, wrap, pending, e.anim, e.frm, e.wr, e.pend);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; tick = 1'b0; run = 1'b0; step = 1'b0; reverse = 1'b0;
      anim_sel = 5'd0; anim_load = 1'b0; immediate = 1'b0; limit = 5'd10;
      expect_next(5'd0, 5'd0, 1'b0, 1'b0);                 // reset state

      // 1: forward free run, limit 10
      run = 1'b1;
      expect_next(5'd0, 5'd0, 1'b0, 1'b0);                 // IDLE -> RUN, no advance
      for (int i = 0; i < 12; i++) begin
         tick = 1'b1;
         expect_next(5'd0, 5'((i + 1) % 10), (i == 9), 1'b0);
      end

      // 2: reverse with limit 6 from frame 0
      anim_load = 1'b1; immediate = 1'b1; anim_sel = 5'd0;
      expect_next(5'd0, 5'd0, 1'b0, 1'b0);
      limit = 5'd6; reverse = 1'b1;
      tick = 1'b1; expect_next(5'd0, 5'd5, 1'b1, 1'b0);
      tick = 1'b1; expect_next(5'd0, 5'd4, 1'b0, 1'b0);
      tick = 1'b1; expect_next(5'd0, 5'd3, 1'b0, 1'b0);

      // 3: queued switch applied at wrap
      reverse = 1'b0;
      tick = 1'b1; expect_next(5'd0, 5'd4, 1'b0, 1'b0);
      anim_load = 1'b1; anim_sel = 5'd1;
      expect_next(5'd0, 5'd4, 1'b0, 1'b1);
      tick = 1'b1; expect_next(5'd0, 5'd5, 1'b0, 1'b1);
      tick = 1'b1; expect_next(5'd1, 5'd0, 1'b1, 1'b0);
      limit = 5'd8;
      tick = 1'b1; expect_next(5'd1, 5'd1, 1'b0, 1'b0);

      // 4: immediate load with concurrent tick, then full 32-frame cycle
      anim_load = 1'b1; immediate = 1'b1; anim_sel = 5'd31; tick = 1'b1; limit = 5'd0;
      expect_next(5'd31, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         tick = 1'b1;
         expect_next(5'd31, 5'((i + 1) % 32), (i == 31), 1'b0);
      end

      // 5: pause, ticks ignored, steps advance
      run = 1'b0;
      expect_next(5'd31, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick = 1'b1;
         expect_next(5'd31, 5'd0, 1'b0, 1'b0);
      end
      step = 1'b1; expect_next(5'd31, 5'd1, 1'b0, 1'b0);
      step = 1'b1; expect_next(5'd31, 5'd2, 1'b0, 1'b0);
      limit = 5'd1;
      step = 1'b1; expect_next(5'd31, 5'd0, 1'b1, 1'b0);
      step = 1'b1; expect_next(5'd31, 5'd0, 1'b1, 1'b0);
      limit = 5'd0;
      step = 1'b1; tick = 1'b1; expect_next(5'd31, 5'd1, 1'b0, 1'b0);
      reverse = 1'b1;
      step = 1'b1; expect_next(5'd31, 5'd0, 1'b0, 1'b0);
      step = 1'b1; expect_next(5'd31, 5'd31, 1'b1, 1'b0);
      limit = 5'd10;                                        // shrink below frame: reverse clamps
      step = 1'b1; expect_next(5'd31, 5'd9, 1'b0, 1'b0);

      // 6: reset with a pending switch
      run = 1'b1;
      expect_next(5'd31, 5'd9, 1'b0, 1'b0);
      anim_load = 1'b1; anim_sel = 5'd5;
      expect_next(5'd31, 5'd9, 1'b0, 1'b1);
      tick = 1'b1; expect_next(5'd31, 5'd8, 1'b0, 1'b1);
      tick = 1'b1; expect_next(5'd31, 5'd7, 1'b0, 1'b1);
      rst = 1'b1; tick = 1'b1; expect_next(5'd0, 5'd0, 1'b0, 1'b0);
      run = 1'b0;
      tick = 1'b1; expect_next(5'd0, 5'd0, 1'b0, 1'b0);
      run = 1'b1;
      tick = 1'b1; expect_next(5'd0, 5'd0, 1'b0, 1'b0);  // still IDLE on this edge
      reverse = 1'b0;
      tick = 1'b1; expect_next(5'd0, 5'd1, 1'b0, 1'b0);

      // load coincident with wrapping advance overrides the stored request
      anim_load = 1'b1; anim_sel = 5'd3;
      expect_next(5'd0, 5'd1, 1'b0, 1'b1);
      limit = 5'd2; anim_load = 1'b1; anim_sel = 5'd7; tick = 1'b1;
      expect_next(5'd7, 5'd0, 1'b1, 1'b0);
      tick = 1'b1; expect_next(5'd7, 5'd1, 1'b0, 1'b0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: scoreboard entries left %0d, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
